thermo_expander: RTL and testbench

- Sequential inverse of the 4-input ones-counter.
- Accepts a population count over a valid/ready handshake and rebuilds the canonical word with that many ones: a thermometer code with the low `count` bits set.
- Emits the word serially (LSB first, one bit per cycle), then presents it in parallel for one cycle.
- Sits downstream of the ones-counter; used as a pattern source for counter self-test and for pulse-train generation.

---
 rtl/thermo_pkg.sv | 27 ++
 rtl/thermo_expander_shreg.sv | 60 ++++++
 rtl/thermo_expander.sv | 114 +++++++++++
 tb/tb_thermo_expander.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer-code expander.
//   FRAME_W_DEF : default frame width
//   THERM_MAX_W : widest word therm() can build
//   state_t     : expander FSM states
//   therm()     : thermometer word with the low `count` bits set
package thermo_pkg;

    localparam int FRAME_W_DEF = 4;
    localparam int THERM_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers truncate the result to their frame width.
    function automatic logic [THERM_MAX_W-1:0] therm(input int unsigned count);
        logic [THERM_MAX_W-1:0] w;
        if (count >= THERM_MAX_W)
            w = '1;
        else
            w = (THERM_MAX_W'(1) << count) - THERM_MAX_W'(1);
        return w;
    endfunction

endpackage

// File: rtl/thermo_expander_shreg.sv
// Loadable shift register that serialises a thermometer word LSB first.
// It keeps a shadow copy of the loaded word and publishes it on capture.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val into the shift register and the shadow copy
//   shift     : shift the register right by one bit
//   capture   : copy the shadow word to frame_out
//   load_val  : word to load
//   ser_bit   : current LSB of the shift register
//   frame_out : last captured word, held until the next capture
module therm_shreg
    import thermo_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic               capture,
    input  logic [FRAME_W-1:0] load_val,
    output logic               ser_bit,
    output logic [FRAME_W-1:0] frame_out
);

    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        shreg_d  = shreg_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        if (load) begin
            shreg_d  = load_val;
            shadow_d = load_val;
        end else if (shift) begin
            shreg_d = shreg_q >> 1;
        end
        // The shadow still holds the current frame here: a new load can
        // only happen after the frame has been captured.
        if (capture)
            frame_d = shadow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
        end else begin
            shreg_q  <= shreg_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
        end
    end

    assign ser_bit   = shreg_q[0];
    assign frame_out = frame_q;

endmodule

// File: rtl/thermo_expander.sv
// Rebuilds a thermometer word from a population count, sends it serially
// LSB first and then presents it in parallel for one cycle.
//   clk, rst    : clock, async active-high reset
//   in_valid    : in_count is valid
//   in_ready    : a count can be accepted this cycle (state only)
//   in_count    : number of ones requested
//   ser_out     : serial bit, ser_valid qualifies it, ser_last marks the end
//   frame_out   : parallel thermometer word, qualified by frame_valid
//   err         : one-cycle strobe, requested count exceeded FRAME_W
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a count
// SEND  | shifting the frame out, one bit per cycle
// DONE  | frame_out valid for one cycle; may accept the next count
module thermo_expander
    import thermo_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CNT_W-1:0]   in_count,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               ser_last,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    output logic               err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(FRAME_W);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic               accept;
    logic               load;
    logic               capture;
    logic               ser_bit;
    logic [FRAME_W-1:0] load_val;

    assign load_val = FRAME_W'(therm(32'(in_count)));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        in_ready    = (state_q != SEND);
        ser_valid   = (state_q == SEND);
        ser_last    = (state_q == SEND) && (idx_q == LAST_IDX);
        frame_valid = (state_q == DONE);
        accept      = in_valid & in_ready;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (in_count <= MAX_CNT) begin
                        state_d = SEND;
                        idx_d   = '0;
                        load    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                idx_d = idx_q + CNT_W'(1);
                if (ser_last) begin
                    state_d = DONE;
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Shift register contents are stale outside SEND, so gate the bit.
    assign ser_out = ser_valid & ser_bit;
    assign err     = err_q;

    therm_shreg #(
        .FRAME_W (FRAME_W)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (ser_valid),
        .capture   (capture),
        .load_val  (load_val),
        .ser_bit   (ser_bit),
        .frame_out (frame_out)
    );

endmodule

// File: tb/tb_thermo_expander.sv
// Self-checking bench for thermo_expander (FRAME_W=4): directed scenarios
// followed by random counts, with a scoreboard of expected frames/rejects.
module tb_thermo_expander;
    import thermo_pkg::*;

    localparam int FW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_count = '0;
    logic          in_ready;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_last;
    logic [FW-1:0] frame_out;
    logic          frame_valid;
    logic          err;

    always #5 clk = ~clk;

    thermo_expander #(
        .FRAME_W (FW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_count    (in_count),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .ser_last    (ser_last),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .err         (err)
    );

    typedef struct packed {
        logic          is_err;
        logic [FW-1:0] frame;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_mis = 0;
    logic [FW-1:0] ser_word = '0;
    int            ser_n = 0;
    logic [FW-1:0] last_frame = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: collects serial bits and pops one expectation per
    // frame_valid or err strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ser_n = 0;
        end else begin
            if (ser_valid) begin
                chk("ser_last", 32'(ser_last), 32'(ser_n == FW - 1));
                if (ser_n < FW) ser_word[ser_n] = ser_out;
                ser_n++;
            end
            if (frame_valid || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    if (e.is_err) begin
                        chk("err_strobe", 32'(err), 1);
                        chk("err_no_frame", 32'(frame_valid), 0);
                        chk("err_ready", 32'(in_ready), 1);
                        chk("err_frame_hold", 32'(frame_out), 32'(last_frame));
                    end else begin
                        chk("frame_valid", 32'(frame_valid), 1);
                        chk("frame_no_err", 32'(err), 0);
                        chk("frame_out", 32'(frame_out), 32'(e.frame));
                        chk("popcount", $countones(frame_out), 32'(e.cnt));
                        chk("ser_bit_count", ser_n, FW);
                        chk("ser_vs_par", 32'(ser_word), 32'(frame_out));
                        last_frame = e.frame;
                    end
                end
                ser_n = 0;
            end
        end
    end

    // Present a count, wait (bounded) for the handshake, log the expectation.
    task automatic drive(input logic [CW-1:0] c, input bit hold, output int waited);
        exp_t e;
        in_valid = 1'b1;
        in_count = c;
        waited   = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            waited++;
            if (in_ready) break;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
        e.is_err = (c > CW'(FW));
        e.cnt    = c;
        e.frame  = e.is_err ? '0 : FW'(therm(32'(c)));
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            n++;
            if (frame_valid) break;
        end
        if (!frame_valid) chk("frame_timeout", 32'(frame_valid), 1);
    endtask

    initial begin
        int            w;
        int            n;
        logic          acc;
        logic [FW-1:0] pat;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_ser_out", 32'(ser_out), 0);
        chk("rst_ser_valid", 32'(ser_valid), 0);
        chk("rst_ser_last", 32'(ser_last), 0);
        chk("rst_frame_out", 32'(frame_out), 0);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // count=3: serial 1,1,1,0 then 0111 in cycle 5
        pat = 4'b0111;
        drive(3'd3, 1'b0, w);
        for (int k = 0; k < FW; k++) begin
            @(negedge clk);
            chk("t1_ser_valid", 32'(ser_valid), 1);
            chk("t1_ser_out", 32'(ser_out), 32'(pat[k]));
            chk("t1_ser_last", 32'(ser_last), 32'(k == FW - 1));
            chk("t1_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        chk("t1_frame_valid", 32'(frame_valid), 1);
        chk("t1_frame_out", 32'(frame_out), 32'h7);
        chk("t1_ready_done", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // count=0 then count=4 back to back, in_valid held
        drive(3'd0, 1'b1, w);
        chk("t2_first_wait", w, 1);
        drive(3'd4, 1'b0, w);
        chk("t2_second_in_done", w, FW + 1);
        wait_frame(n);
        chk("t2_second_latency", n, FW + 1);
        chk("t2_frame_ones", 32'(frame_out), 32'hF);
        @(posedge clk);
        #1;

        // count=5: rejected
        drive(3'd5, 1'b0, w);
        @(negedge clk);
        chk("t3_err", 32'(err), 1);
        chk("t3_no_ser", 32'(ser_valid), 0);
        chk("t3_ready", 32'(in_ready), 1);
        chk("t3_frame_hold", 32'(frame_out), 32'hF);
        @(negedge clk);
        chk("t3_err_one_cycle", 32'(err), 0);
        chk("t3_no_ser_after", 32'(ser_valid), 0);
        @(posedge clk);
        #1;

        // in_valid pulsed during SEND is ignored
        drive(3'd1, 1'b0, w);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_count = 3'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_frame(n);
        chk("t4_latency", n, 3);
        chk("t4_frame", 32'(frame_out), 32'h1);
        acc = 1'b0;
        repeat (8) begin
            @(negedge clk);
            acc = acc | ser_valid | frame_valid;
        end
        chk("t4_no_second_frame", 32'(acc), 0);
        @(posedge clk);
        #1;

        // reset in cycle 2 of a count-4 frame
        drive(3'd4, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        last_frame = '0;
        #1;
        chk("t5_ser_valid", 32'(ser_valid), 0);
        chk("t5_ser_out", 32'(ser_out), 0);
        chk("t5_ser_last", 32'(ser_last), 0);
        chk("t5_frame_out", 32'(frame_out), 0);
        chk("t5_frame_valid", 32'(frame_valid), 0);
        chk("t5_err", 32'(err), 0);
        chk("t5_in_ready", 32'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(3'd1, 1'b0, w);
        wait_frame(n);
        chk("t5_latency", n, FW + 1);
        chk("t5_frame", 32'(frame_out), 32'h1);
        @(posedge clk);
        #1;

        // random counts with random gaps
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            drive(CW'($urandom_range(0, 7)), 1'b0, w);
        end
        for (int t = 0; t < 40; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
